// File: rtl/radix3_commutator_pkg.sv
// Shared definitions for the radix-3 commutator.
// Holds the lane count, mode encodings and the switch select helper.
package radix3_commutator_pkg;

  localparam int LANES = 3;

  typedef enum logic {
    MODE_TRANSPOSE = 1'b0,
    MODE_BYPASS    = 1'b1
  } mode_e;

  // (s - j) mod 3 for s, j in 0..2
  function automatic logic [1:0] sel3(
    input logic [1:0] s,
    input logic [1:0] j
  );
    logic [2:0] t;
    t = {1'b0, s} + 3'd3 - {1'b0, j};
    if (t >= 3'd3) begin
      t = t - 3'd3;
    end
    return t[1:0];
  endfunction

endpackage

// File: rtl/radix3_delay_line.sv
// Enable-gated shift register delay line of DEPTH samples.
// Ports: clk, rst_n, en (shift), d (in), q (d delayed DEPTH enables).
module radix3_delay_line #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused;
    assign unused = ^{clk, rst_n, en};
    assign q = d;
  end else begin : g_shift
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end else if (en) begin
        mem[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          mem[i] <= mem[i-1];
        end
      end
    end

    assign q = mem[DEPTH-1];
  end

endmodule

// File: rtl/radix3_commutator.sv
// Radix-3 delay commutator: 3x3 block transpose of L-sample segments.
// Ports: clk, rst_n, in_valid/in_sof/mode, a/b/c in; ao/bo/co, out_valid/out_sof/out_err.
module radix3_commutator
  import radix3_commutator_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int L      = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] ao,
  output logic [DATA_W-1:0] bo,
  output logic [DATA_W-1:0] co,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_err
);

  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam int FW = $clog2(2 * L + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_cur;
  logic [1:0]    s_q;
  logic [1:0]    s_cur;
  logic [FW-1:0] fill;
  logic          primed;
  logic          mode_q;
  logic          mode_cur;
  logic          seen;
  logic          sof_v;
  logic          sof_dly;

  logic [DATA_W-1:0] lane_in [LANES];
  logic [DATA_W-1:0] d1      [LANES];
  logic [DATA_W-1:0] d2      [LANES];

  assign lane_in[0] = a;
  assign lane_in[1] = b;
  assign lane_in[2] = c;

  // a qualified sof restarts the block on this very sample
  assign sof_v    = in_valid & in_sof;
  assign cnt_cur  = sof_v ? '0 : cnt_q;
  assign s_cur    = sof_v ? 2'd0 : s_q;
  assign mode_cur = sof_v ? mode : mode_q;

  for (genvar k = 0; k < LANES; k++) begin : g_s1
    radix3_delay_line #(
      .DATA_W(DATA_W),
      .DEPTH (k * L)
    ) u_dl (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (in_valid),
      .d    (lane_in[k]),
      .q    (d1[k])
    );
  end

  for (genvar j = 0; j < LANES; j++) begin : g_s2
    logic [1:0]        sel;
    logic [DATA_W-1:0] sw;

    assign sel = (mode_cur == MODE_BYPASS) ? 2'(j)
                                           : sel3(s_cur, 2'(j));

    always_comb begin
      sw = d1[0];
      case (sel)
        2'd1:    sw = d1[1];
        2'd2:    sw = d1[2];
        default: sw = d1[0];
      endcase
    end

    radix3_delay_line #(
      .DATA_W(DATA_W),
      .DEPTH ((2 - j) * L)
    ) u_dl (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (in_valid),
      .d    (sw),
      .q    (d2[j])
    );
  end

  radix3_delay_line #(
    .DATA_W(1),
    .DEPTH (2 * L)
  ) u_sof (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (in_valid),
    .d    (in_sof),
    .q    (sof_dly)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      s_q     <= '0;
      fill    <= '0;
      primed  <= 1'b0;
      mode_q  <= 1'b0;
      seen    <= 1'b0;
      out_err <= 1'b0;
    end else if (in_valid) begin
      if (cnt_cur == CW'(L - 1)) begin
        cnt_q <= '0;
        s_q   <= (s_cur == 2'd2) ? 2'd0 : s_cur + 2'd1;
      end else begin
        cnt_q <= cnt_cur + 1'b1;
        s_q   <= s_cur;
      end
      if (in_sof) begin
        mode_q <= mode;
        seen   <= 1'b1;
        if (seen && (cnt_q != '0 || s_q != 2'd0)) begin
          out_err <= 1'b1;
        end
      end
      // primed once the delay lines hold 2L real samples
      if (!primed) begin
        fill <= fill + 1'b1;
        if (fill == FW'(2 * L - 1)) begin
          primed <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      ao        <= '0;
      bo        <= '0;
      co        <= '0;
    end else begin
      out_valid <= in_valid & primed;
      out_sof   <= in_valid & primed & sof_dly;
      if (in_valid && primed) begin
        ao <= d2[0];
        bo <= d2[1];
        co <= d2[2];
      end
    end
  end

endmodule

// File: tb/tb_radix3_commutator.sv
// Directed bench for radix3_commutator at L=2, L=1 and L=9.
// Expected outputs come from the closed-form block transpose pattern.
module tb_radix3_commutator;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int Ls [3] = '{2, 1, 9};

  logic [2:0]  vld;
  logic [2:0]  sof;
  logic [2:0]  md;
  logic [31:0] ai [3];
  logic [31:0] bi [3];
  logic [31:0] ci [3];
  logic [31:0] oa [3];
  logic [31:0] ob [3];
  logic [31:0] oc [3];
  logic [2:0]  ov;
  logic [2:0]  os;
  logic [2:0]  oe;

  logic [95:0] last;
  bit          known;

  radix3_commutator #(.DATA_W(32), .L(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_sof(sof[0]),
    .mode(md[0]), .a(ai[0]), .b(bi[0]), .c(ci[0]),
    .ao(oa[0]), .bo(ob[0]), .co(oc[0]),
    .out_valid(ov[0]), .out_sof(os[0]), .out_err(oe[0])
  );

  radix3_commutator #(.DATA_W(32), .L(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_sof(sof[1]),
    .mode(md[1]), .a(ai[1]), .b(bi[1]), .c(ci[1]),
    .ao(oa[1]), .bo(ob[1]), .co(oc[1]),
    .out_valid(ov[1]), .out_sof(os[1]), .out_err(oe[1])
  );

  radix3_commutator #(.DATA_W(32), .L(9)) u_l9 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_sof(sof[2]),
    .mode(md[2]), .a(ai[2]), .b(bi[2]), .c(ci[2]),
    .ao(oa[2]), .bo(ob[2]), .co(oc[2]),
    .out_valid(ov[2]), .out_sof(os[2]), .out_err(oe[2])
  );

  task automatic chk(input string tag, input logic [98:0] got,
                     input logic [98:0] exp, input logic [98:0] mask);
    checks++;
    assert ((got & mask) === (exp & mask)) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got & mask, exp & mask);
    end
  endtask

  function automatic logic [98:0] grab(input int d);
    return {ov[d], os[d], oe[d], oa[d], ob[d], oc[d]};
  endfunction

  task automatic feed(input int d, input bit v, input bit sf, input bit m,
                      input logic [31:0] xa, input logic [31:0] xb,
                      input logic [31:0] xc);
    vld = '0;
    sof = '0;
    md = '0;
    vld[d] = v;
    sof[d] = sf;
    md[d] = m;
    ai[d] = xa;
    bi[d] = xb;
    ci[d] = xc;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all(input string tag);
    vld = '0;
    sof = '0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk(tag, grab(d), '0, {99{1'b1}});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    last = '0;
    known = 1'b1;
  endtask

  task automatic run_stream(input int d, input int nsamp, input bit m,
                            input int gap, input bit warm, input bit errx,
                            input string tag);
    int L;
    int n;
    int guard;
    int f;
    int t;
    int i;
    int p;
    int u;
    bit v;
    bit sf;
    logic [31:0] xa;
    logic [31:0] e [3];
    L = Ls[d];
    n = 0;
    guard = 0;
    while (n < nsamp && guard < 5000) begin
      guard++;
      v = ($urandom_range(99) >= gap);
      if (v) begin
        f = n / (3 * L);
        t = (n / L) % 3;
        i = n % L;
        xa = 32'(4096 * f + 16 * t + i);
        sf = (n % (3 * L) == 0);
        // mode flips on every non-sof sample and must be ignored there
        feed(d, 1'b1, sf, sf ? m : ~m, xa, xa + 32'h100, xa + 32'h200);
      end else begin
        feed(d, 1'b0, 1'b1, ~m, $urandom, $urandom, $urandom);
      end
      if (v && n >= 2 * L) begin
        p = n - 2 * L;
        f = p / (3 * L);
        u = (p / L) % 3;
        i = p % L;
        for (int j = 0; j < 3; j++) begin
          if (m == 1'b0) begin
            e[j] = 32'(4096 * f + 256 * u + 16 * j + i);
          end else begin
            e[j] = 32'(4096 * f + 256 * j + 16 * u + i);
          end
        end
        chk(tag, grab(d),
            {1'b1, (p % (3 * L) == 0), errx, e[0], e[1], e[2]},
            {99{1'b1}});
        last = {e[0], e[1], e[2]};
        known = 1'b1;
      end else if (v && warm) begin
        chk(tag, grab(d), {1'b1, 1'b0, errx, 96'd0},
            {1'b1, 1'b0, 1'b1, 96'd0});
        known = 1'b0;
      end else begin
        chk(tag, grab(d), {1'b0, 1'b0, errx, last},
            {3'b111, known ? {96{1'b1}} : 96'd0});
      end
      if (v) n++;
    end
    if (guard >= 5000) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout got=%0d exp=%0d", tag, n, nsamp);
    end
  endtask

  initial begin
    vld = '0;
    sof = '0;
    md = '0;
    for (int d = 0; d < 3; d++) begin
      ai[d] = '0;
      bi[d] = '0;
      ci[d] = '0;
    end
    last = '0;
    known = 1'b1;

    reset_all("reset_state");
    run_stream(0, 12, 1'b0, 0, 1'b0, 1'b0, "l2_transpose");

    reset_all("reset2");
    run_stream(0, 12, 1'b1, 0, 1'b0, 1'b0, "l2_bypass");

    reset_all("reset3");
    run_stream(0, 18, 1'b0, 50, 1'b0, 1'b0, "l2_gaps");

    // aligned sof is fine, a second one one sample later is not
    feed(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h100, 32'h200);
    chk("aligned_sof_no_err", grab(0), 99'd0, {3'b001, 96'd0});
    feed(0, 1'b1, 1'b1, 1'b0, 32'h1, 32'h101, 32'h201);
    chk("misaligned_sof_err", grab(0), {3'b001, 96'd0}, {3'b001, 96'd0});
    known = 1'b0;
    run_stream(0, 12, 1'b0, 0, 1'b1, 1'b1, "realign");

    run_stream(0, 5, 1'b0, 0, 1'b1, 1'b1, "pre_rst");
    reset_all("midframe_rst");
    run_stream(0, 12, 1'b0, 0, 1'b0, 1'b0, "post_rst");

    reset_all("reset_l1");
    run_stream(1, 6, 1'b0, 0, 1'b0, 1'b0, "l1_b2b");

    reset_all("reset_l9");
    run_stream(2, 54, 1'b0, 0, 1'b0, 1'b0, "l9_b2b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
